// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer wait controller.
package reaction_pkg;

    localparam int REACT_W = 14;
    localparam int RAND_W  = 13;
    localparam logic [REACT_W-1:0] BEST_NONE = 14'h3FFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        REACT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Worst case is 1000 + 8191 = 9191, so the 14-bit sum never wraps.
    function automatic logic [REACT_W-1:0] wait_init(input logic [RAND_W-1:0] rnd,
                                                      input int min_ms);
        return REACT_W'(min_ms) + {1'b0, rnd};
    endfunction

endpackage

// File: rtl/reaction_wait_ctrl_button_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The rise pulse appears three clocks after the raw input goes high.
module button_sync_edge (
    input  logic Clk,
    input  logic Rst,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

endmodule

// File: rtl/reaction_wait_ctrl.sv
// Random-wait reaction timer: waits MIN_WAIT_MS + RandomValue ms, lights the LED, times the press.
// Optional best-score tracking is enabled with the REACTION_BEST_EN macro.
module reaction_wait_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 1000,
    parameter int MIN_WAIT_MS  = 1000,
    parameter int MAX_REACT_MS = 9999
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Button,
    input  logic [RAND_W-1:0] RandomValue,
    output logic              LedOn,
    output logic              Busy,
    output logic              Done,
    output logic [REACT_W-1:0] ReactionMs,
    output logic              Early,
    output logic              Timeout,
    output logic [1:0]        state_dbg
`ifdef REACTION_BEST_EN
    ,
    output logic [REACT_W-1:0] BestMs
`endif
);

    localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [REACT_W-1:0] REACT_MAX  = REACT_W'(MAX_REACT_MS);

    state_t               state_q, state_d;
    logic [REACT_W-1:0]   wait_q, wait_d;
    logic [REACT_W-1:0]   react_q, react_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 led_d, done_d, early_d, timeout_d;
    logic [REACT_W-1:0]   rms_d;
    logic                 press;
    logic                 tick;

    button_sync_edge u_btn (
        .Clk      (Clk),
        .Rst      (Rst),
        .async_in (Button),
        .rise     (press)
    );

    assign tick      = (presc_q == PRESC_LAST);
    assign Busy      = (state_q == WAIT) || (state_q == REACT);
    assign state_dbg = state_q;

`ifdef REACTION_BEST_EN
    logic [REACT_W-1:0] best_q, best_d;
    assign BestMs = best_q;
`endif

    // Start is a one-cycle request accepted only when not Busy; Done is a
    // one-cycle strobe marking ReactionMs/Early/Timeout as freshly valid.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        react_d   = react_q;
        presc_d   = presc_q;
        led_d     = LedOn;
        done_d    = 1'b0;
        rms_d     = ReactionMs;
        early_d   = Early;
        timeout_d = Timeout;
`ifdef REACTION_BEST_EN
        best_d    = best_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d   = WAIT;
                    wait_d    = wait_init(RandomValue, MIN_WAIT_MS);
                    presc_d   = '0;
                    rms_d     = '0;
                    early_d   = 1'b0;
                    timeout_d = 1'b0;
                    led_d     = 1'b0;
                end
            end
            WAIT: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (press) begin
                    early_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (tick) begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == REACT_W'(1)) begin
                        state_d = REACT;
                        led_d   = 1'b1;
                        react_d = '0;
                        presc_d = '0;
                    end
                end
            end
            REACT: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) react_d = react_q + 1'b1;
                // A press wins over a coincident timeout tick and reports the pre-tick count.
                if (press) begin
                    rms_d   = react_q;
                    led_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef REACTION_BEST_EN
                    if (react_q < best_q) best_d = react_q;
`endif
                end else if (tick && (react_q + 1'b1 == REACT_MAX)) begin
                    rms_d     = REACT_MAX;
                    timeout_d = 1'b1;
                    led_d     = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wait_q     <= '0;
            react_q    <= '0;
            presc_q    <= '0;
            LedOn      <= 1'b0;
            Done       <= 1'b0;
            ReactionMs <= '0;
            Early      <= 1'b0;
            Timeout    <= 1'b0;
        end else begin
            wait_q     <= wait_d;
            react_q    <= react_d;
            presc_q    <= presc_d;
            LedOn      <= led_d;
            Done       <= done_d;
            ReactionMs <= rms_d;
            Early      <= early_d;
            Timeout    <= timeout_d;
        end
    end

`ifdef REACTION_BEST_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) best_q <= BEST_NONE;
        else      best_q <= best_d;
    end
`endif

endmodule

// File: tb/tb_reaction_wait_ctrl.sv
// Scoreboard bench for reaction_wait_ctrl with TICK_DIV=4, MIN_WAIT_MS=2.
module tb_reaction_wait_ctrl;
    import reaction_pkg::*;

    localparam int TD   = 4;
    localparam int MINW = 2;

    logic               Clk = 1'b0;
    logic               Rst = 1'b0;
    logic               Start = 1'b0;
    logic               Button = 1'b0;
    logic [RAND_W-1:0]  RandomValue = '0;
    logic               LedOn, Busy, Done, Early, Timeout;
    logic [REACT_W-1:0] ReactionMs;
    logic [1:0]         state_dbg;
`ifdef REACTION_BEST_EN
    logic [REACT_W-1:0] BestMs;
`endif

    reaction_wait_ctrl #(.TICK_DIV(TD), .MIN_WAIT_MS(MINW), .MAX_REACT_MS(9999)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .Button      (Button),
        .RandomValue (RandomValue),
        .LedOn       (LedOn),
        .Busy        (Busy),
        .Done        (Done),
        .ReactionMs  (ReactionMs),
        .Early       (Early),
        .Timeout     (Timeout),
        .state_dbg   (state_dbg)
`ifdef REACTION_BEST_EN
        ,
        .BestMs      (BestMs)
`endif
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    // {best, early, timeout, reaction}
    logic [29:0] exp_q[$];
    logic [REACT_W-1:0] model_best = BEST_NONE;
    int cyc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int react, input logic early, input logic to);
        exp_q.push_back({model_best, early, to, REACT_W'(react)});
    endtask

    // Monitor: pop one expected result per Done strobe.
    logic prev_done = 1'b0;
    always @(negedge Clk) begin
        logic [29:0] e;
        if (Done && prev_done) check("done_one_cycle", 1, 0);
        if (Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("reaction_ms", int'(ReactionMs), int'(e[13:0]));
                check("timeout", int'(Timeout), int'(e[14]));
                check("early", int'(Early), int'(e[15]));
`ifdef REACTION_BEST_EN
                check("best_ms", int'(BestMs), int'(e[29:16]));
`endif
            end
        end
        prev_done = Done;
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clk);
        cyc += n;
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (Busy && k < bound) begin
            @(negedge Clk);
            k++;
        end
        check("busy_clear", int'(Busy), 0);
    endtask

    task automatic start_pulse(input int rv);
        @(negedge Clk);
        RandomValue = RAND_W'(rv);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        RandomValue = RAND_W'($urandom_range(0, 8191));
        cyc = 1;
        check("busy_after_start", int'(Busy), 1);
    endtask

    // Full press run; inject_at>0 fires an extra Start mid-WAIT that must be ignored.
    task automatic do_run(input int rv, input int react, input int inject_at);
        int n = MINW + rv;
        start_pulse(rv);
        while (cyc < n * TD) begin
            if (cyc == inject_at) begin
                Start = 1'b1;
                RandomValue = RAND_W'(1);
            end else begin
                Start = 1'b0;
            end
            step(1);
        end
        Start = 1'b0;
        check("led_before_rise", int'(LedOn), 0);
        step(1);
        check("led_rise", int'(LedOn), 1);
        step(react * TD - 1);
        if (react < int'(model_best)) model_best = REACT_W'(react);
        push_exp(react, 1'b0, 1'b0);
        Button = 1'b1;
        wait_idle(40);
        check("led_off_after_press", int'(LedOn), 0);
        step(2);
        Button = 1'b0;
        step(4);
    endtask

    initial begin
        logic led_seen;
        // Reset held with Start toggling: nothing must start.
        Start = 1'b1;
        RandomValue = RAND_W'(5);
        repeat (4) @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        step(3);
        check("rst_busy", int'(Busy), 0);
        check("rst_led", int'(LedOn), 0);
        check("rst_done", int'(Done), 0);
        check("rst_flags", int'({Early, Timeout}), 0);
        check("rst_reaction", int'(ReactionMs), 0);
        check("rst_state", int'(state_dbg), 0);
`ifdef REACTION_BEST_EN
        check("rst_best", int'(BestMs), int'(BEST_NONE));
`endif

        // Normal press at reaction count 7.
        do_run(3, 7, 0);

        // False start: raw press 8 cycles after Start, LED must never light.
        start_pulse(5);
        step(7);
        push_exp(0, 1'b1, 1'b0);
        Button = 1'b1;
        led_seen = 1'b0;
        for (int i = 0; i < 60 && Busy; i++) begin
            if (LedOn) led_seen = 1'b1;
            step(1);
        end
        check("early_led_never", int'(led_seen | LedOn), 0);
        check("early_idle", int'(Busy), 0);
        step(2);
        Button = 1'b0;
        step(4);

        // Timeout after 9999 ticks with no press.
        start_pulse(0);
        step(MINW * TD - 1);
        check("to_led_before", int'(LedOn), 0);
        step(1);
        check("to_led_rise", int'(LedOn), 1);
        push_exp(9999, 1'b0, 1'b1);
        wait_idle(9999 * TD + 100);
        check("to_led_off", int'(LedOn), 0);
        step(3);

        // Maximum random offset plus an ignored Start mid-WAIT.
        do_run(8191, 3, 100);

        // Async reset during REACT drops the LED immediately.
        start_pulse(0);
        step(MINW * TD);
        check("pre_reset_led", int'(LedOn), 1);
        Rst = 1'b0;
        #1;
        check("async_reset_led", int'(LedOn), 0);
        check("async_reset_busy", int'(Busy), 0);
        model_best = BEST_NONE;
        @(negedge Clk);
        Rst = 1'b1;
        step(3);

`ifdef REACTION_BEST_EN
        check("best_after_reset", int'(BestMs), int'(BEST_NONE));
        do_run(0, 12, 0);
        do_run(0, 5, 0);
        do_run(0, 9, 0);
        start_pulse(1);
        step(3);
        push_exp(0, 1'b1, 1'b0);
        Button = 1'b1;
        wait_idle(40);
        step(2);
        Button = 1'b0;
        step(4);
        check("best_after_early", int'(BestMs), 5);
        Rst = 1'b0;
        #1;
        check("best_rst_clear", int'(BestMs), int'(BEST_NONE));
        @(negedge Clk);
        Rst = 1'b1;
        step(2);
`endif

        check("exp_queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
